// File: rtl/frame_accumulator.sv
// rtl/frame_accumulator.sv - pipelined signed frame accumulator with saturating/wrapping registered output
module frame_accumulator #(
    parameter int DATA_W = 16,
    parameter int TAPS   = 8,
    parameter int OUT_W  = 16,
    parameter int SAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_sum,
    output logic              out_ovf
);

    localparam int ACC_W = DATA_W + $clog2(TAPS);
    localparam int CNT_W = $clog2(TAPS);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             accept;
    logic             ovf;
    logic [OUT_W-1:0] res;
    logic [ACC_W-OUT_W:0] upper;

    assign last     = (cnt == CNT_W'(TAPS - 1));
    assign in_ready = !clr && !(last && out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign acc_next = ((cnt == '0) ? '0 : acc)
                    + {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};

    // The total fits in OUT_W signed exactly when all bits from the OUT_W sign bit upward agree.
    assign upper = acc_next[ACC_W-1:OUT_W-1];
    assign ovf   = !((&upper) || (~|upper));

    always_comb begin
        res = acc_next[OUT_W-1:0];
        if (SAT != 0 && ovf) begin
            res = acc_next[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                    : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (clr) begin
                cnt <= '0;
                acc <= '0;
            end else if (accept) begin
                if (last) begin
                    // A load overrides any same-cycle drain, so back-to-back results never bubble.
                    cnt       <= '0;
                    out_valid <= 1'b1;
                    out_sum   <= res;
                    out_ovf   <= ovf;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                    acc <= acc_next;
                end
            end
        end
    end

endmodule
